// File: rtl/imem_loader.sv
// Boot loader: assembles a length/data/checksum byte stream into LE words,
// writes them to instruction memory and releases the core on a good image.
module imem_loader #(
    parameter int DWIDTH     = 32,
    parameter int IMEM_WORDS = 1024
) (
    input  logic              Clk_Core,
    input  logic              Rst_Core_N,
    input  logic              Load_Req,
    input  logic [7:0]        Byte_In,
    input  logic              Byte_Valid,
    output logic              Byte_Ready,
    output logic              Imem_Wr_En,
    output logic [DWIDTH-1:0] Imem_Wr_Addr,
    output logic [DWIDTH-1:0] Imem_Wr_Data,
    output logic              Core_Rst_N,
    output logic              Load_Done,
    output logic              Load_Err,
    output logic [DWIDTH-1:0] Words_Loaded
);

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        WRITE,
        CSUM,
        DONE,
        ERR
    } state_t;

    state_t      state;
    logic [1:0]  byte_cnt;
    logic [31:0] len;
    logic [23:0] shreg;
    logic [7:0]  sum;

    logic        xfer;
    logic        last_byte;
    logic [31:0] len_next;
    logic        last_word;

    assign xfer      = Byte_Valid & Byte_Ready;
    assign last_byte = (byte_cnt == 2'd3);
    assign len_next  = {Byte_In, len[31:8]};
    assign last_word = (Words_Loaded + 1'b1) == DWIDTH'(len);

    always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
        if (!Rst_Core_N) begin
            state        <= IDLE;
            byte_cnt     <= '0;
            len          <= '0;
            shreg        <= '0;
            sum          <= '0;
            Byte_Ready   <= 1'b0;
            Imem_Wr_En   <= 1'b0;
            Imem_Wr_Addr <= '0;
            Imem_Wr_Data <= '0;
            Core_Rst_N   <= 1'b0;
            Load_Done    <= 1'b0;
            Load_Err     <= 1'b0;
            Words_Loaded <= '0;
        end else begin
            Imem_Wr_En <= 1'b0;
            unique case (state)
                IDLE, DONE, ERR: begin
                    if (Load_Req) begin
                        state        <= LEN;
                        byte_cnt     <= '0;
                        len          <= '0;
                        sum          <= '0;
                        Words_Loaded <= '0;
                        Byte_Ready   <= 1'b1;
                        Core_Rst_N   <= 1'b0;
                        Load_Done    <= 1'b0;
                        Load_Err     <= 1'b0;
                    end
                end
                LEN: begin
                    if (xfer) begin
                        len      <= len_next;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (last_byte) begin
                            if (len_next > 32'(IMEM_WORDS)) begin
                                state      <= ERR;
                                Byte_Ready <= 1'b0;
                                Load_Err   <= 1'b1;
                            end else if (len_next == 32'd0) begin
                                state <= CSUM;
                            end else begin
                                state <= DATA;
                            end
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
                        shreg    <= {Byte_In, shreg[23:8]};
                        sum      <= sum + Byte_In;
                        byte_cnt <= byte_cnt + 2'd1;
                        // Word completes: strobe is registered so it lands in WRITE.
                        if (last_byte) begin
                            state        <= WRITE;
                            Byte_Ready   <= 1'b0;
                            Imem_Wr_En   <= 1'b1;
                            Imem_Wr_Addr <= {Words_Loaded[DWIDTH-3:0], 2'b00};
                            Imem_Wr_Data <= DWIDTH'({Byte_In, shreg});
                        end
                    end
                end
                WRITE: begin
                    Words_Loaded <= Words_Loaded + 1'b1;
                    Byte_Ready   <= 1'b1;
                    state        <= last_word ? CSUM : DATA;
                end
                CSUM: begin
                    if (xfer) begin
                        Byte_Ready <= 1'b0;
                        if (Byte_In == sum) begin
                            state      <= DONE;
                            Load_Done  <= 1'b1;
                            Core_Rst_N <= 1'b1;
                        end else begin
                            state    <= ERR;
                            Load_Err <= 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    Byte_Ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
